ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 31 +++
 rtl/ex_stage.sv | 218 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// EX stage port bundle: ID/EX operands in, EX/MEM results and stall request out.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] link_addr_i;
  logic [31:0] offset_i;

  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [7:0]  aluop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] reg2_o;
  logic        stallreq_o;

  // ID/EX side: drives the instruction fields, consumes the results.
  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_addr_i, offset_i,
    input  wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, reg2_o, stallreq_o
  );

  // Execute stage side.
  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_addr_i, offset_i,
    output wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, reg2_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/jump/load-store results and an
// iterative radix-2 restoring divider that stalls the pipeline while it works.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  ex
);

  localparam logic [2:0] SEL_NOP       = 3'b000;
  localparam logic [2:0] SEL_LOGIC     = 3'b001;
  localparam logic [2:0] SEL_SHIFT     = 3'b010;
  localparam logic [2:0] SEL_DIV       = 3'b011;
  localparam logic [2:0] SEL_ARITH     = 3'b100;
  localparam logic [2:0] SEL_JUMP      = 3'b110;
  localparam logic [2:0] SEL_LOADSTORE = 3'b111;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_REM  = 8'h1C;
  localparam logic [7:0] OP_REMU = 8'h1D;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  div_state_t  state_r, state_s;
  logic [5:0]  cnt_r;
  logic [31:0] quo_r;      // dividend shifts out of the top, quotient bits shift in
  logic [31:0] rem_r;
  logic [31:0] dvsr_r;
  logic        neg_q_r, neg_r_r, sel_rem_r;

  logic        is_div_s, is_signed_s, is_rem_s, dvsr_zero_s;
  logic        start_s, zero_start_s, step_s, div_stall_s;
  logic [31:0] div_res_s, alu_res_s;
  logic [32:0] shifted_s, trial_s;

  assign is_div_s    = (ex.alusel_i == SEL_DIV);
  assign is_signed_s = (ex.aluop_i == OP_DIV) || (ex.aluop_i == OP_REM);
  assign is_rem_s    = (ex.aluop_i == OP_REM) || (ex.aluop_i == OP_REMU);
  assign dvsr_zero_s = (ex.reg2_i == 32'd0);

  // One restoring step: bring the next dividend bit into the partial remainder
  // and try subtracting the divisor; a borrow out of bit 32 means "restore".
  assign shifted_s = {rem_r, quo_r[31]};
  assign trial_s   = shifted_s - {1'b0, dvsr_r};

  // Single-cycle result for every class except the divider.
  always_comb begin
    alu_res_s = 32'd0;
    case (ex.alusel_i)
      SEL_LOGIC: begin
        case (ex.aluop_i)
          OP_AND:  alu_res_s = ex.reg1_i & ex.reg2_i;
          OP_OR:   alu_res_s = ex.reg1_i | ex.reg2_i;
          OP_XOR:  alu_res_s = ex.reg1_i ^ ex.reg2_i;
          default: alu_res_s = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (ex.aluop_i)
          OP_SLL:  alu_res_s = ex.reg1_i << ex.reg2_i[4:0];
          OP_SRL:  alu_res_s = ex.reg1_i >> ex.reg2_i[4:0];
          OP_SRA:  alu_res_s = $signed(ex.reg1_i) >>> ex.reg2_i[4:0];
          default: alu_res_s = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (ex.aluop_i)
          OP_ADD, OP_ADDU: alu_res_s = ex.reg1_i + ex.reg2_i;
          OP_SUB, OP_SUBU: alu_res_s = ex.reg1_i - ex.reg2_i;
          OP_SLT:  alu_res_s = {31'd0, ($signed(ex.reg1_i) < $signed(ex.reg2_i))};
          OP_SLTU: alu_res_s = {31'd0, (ex.reg1_i < ex.reg2_i)};
          default: alu_res_s = 32'd0;
        endcase
      end
      SEL_JUMP: alu_res_s = ex.link_addr_i;
      default:  alu_res_s = 32'd0;   // NOP, LOADSTORE, DIV (handled by divider)
    endcase
  end

  // Divider FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Divider next state, stall request and signed fix-up of the final result.
  always_comb begin
    state_s      = state_r;
    start_s      = 1'b0;
    zero_start_s = 1'b0;
    step_s       = 1'b0;
    div_stall_s  = 1'b0;
    div_res_s    = 32'd0;
    case (state_r)
      DIV_IDLE: begin
        if (is_div_s) begin
          div_stall_s = 1'b1;
          if (dvsr_zero_s) begin
            zero_start_s = 1'b1;
            state_s      = DIV_DONE;
          end else begin
            start_s = 1'b1;
            state_s = DIV_BUSY;
          end
        end else begin
          state_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        div_stall_s = 1'b1;
        step_s      = 1'b1;
        if (cnt_r == 6'd31) begin
          state_s = DIV_DONE;
        end else begin
          state_s = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        state_s = DIV_IDLE;
        if (sel_rem_r) begin
          div_res_s = neg_r_r ? neg32(rem_r) : rem_r;
        end else begin
          div_res_s = neg_q_r ? neg32(quo_r) : quo_r;
        end
      end
      default: state_s = DIV_IDLE;
    endcase
  end

  // Divider datapath: latch magnitudes at start, then one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 6'd0;
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      dvsr_r    <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
    end else if (start_s) begin
      cnt_r     <= 6'd0;
      quo_r     <= is_signed_s ? abs32(ex.reg1_i) : ex.reg1_i;
      dvsr_r    <= is_signed_s ? abs32(ex.reg2_i) : ex.reg2_i;
      rem_r     <= 32'd0;
      neg_q_r   <= is_signed_s & (ex.reg1_i[31] ^ ex.reg2_i[31]);
      neg_r_r   <= is_signed_s & ex.reg1_i[31];
      sel_rem_r <= is_rem_s;
    end else if (zero_start_s) begin
      // Divide by zero bypasses the iterations; results are taken verbatim.
      cnt_r     <= 6'd0;
      quo_r     <= 32'hFFFF_FFFF;
      rem_r     <= ex.reg1_i;
      dvsr_r    <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= is_rem_s;
    end else if (step_s) begin
      cnt_r <= cnt_r + 6'd1;
      if (trial_s[32]) begin
        rem_r <= shifted_s[31:0];
        quo_r <= {quo_r[30:0], 1'b0};
      end else begin
        rem_r <= trial_s[31:0];
        quo_r <= {quo_r[30:0], 1'b1};
      end
    end
  end

  // Output mux; everything is forced quiet while reset is held.
  always_comb begin
    if (rst) begin
      ex.wd_o       = 5'd0;
      ex.wreg_o     = 1'b0;
      ex.wdata_o    = 32'd0;
      ex.aluop_o    = OP_NOP;
      ex.mem_addr_o = 32'd0;
      ex.reg2_o     = 32'd0;
      ex.stallreq_o = 1'b0;
    end else begin
      ex.wd_o       = ex.wd_i;
      ex.wreg_o     = ex.wreg_i;
      ex.wdata_o    = is_div_s ? div_res_s : alu_res_s;
      ex.aluop_o    = ex.aluop_i;
      ex.mem_addr_o = ex.reg1_i + ex.offset_i;
      ex.reg2_o     = ex.reg2_i;
      ex.stallreq_o = div_stall_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage with a behavioural reference model and a
// per-cycle compare process, plus literal pins on key results.
module tb_ex_stage;

  localparam logic [2:0] SEL_NOP       = 3'b000;
  localparam logic [2:0] SEL_LOGIC     = 3'b001;
  localparam logic [2:0] SEL_SHIFT     = 3'b010;
  localparam logic [2:0] SEL_DIV       = 3'b011;
  localparam logic [2:0] SEL_ARITH     = 3'b100;
  localparam logic [2:0] SEL_JUMP      = 3'b110;
  localparam logic [2:0] SEL_LOADSTORE = 3'b111;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_REM  = 8'h1C;
  localparam logic [7:0] OP_REMU = 8'h1D;
  localparam logic [7:0] OP_LW   = 8'hE3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   div_age = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] link);
    logic signed [63:0] sa, sb;
    int unsigned        s;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    s  = {27'd0, b[4:0]};
    case (sel)
      SEL_LOGIC: return (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
      SEL_SHIFT: begin
        if (op == OP_SLL) return a << s;
        if (op == OP_SRL) return a >> s;
        return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      end
      SEL_ARITH: begin
        if (op == OP_ADD || op == OP_ADDU) return a + b;
        if (op == OP_SUB || op == OP_SUBU) return a - b;
        if (op == OP_SLT) return (sa < sb) ? 32'd1 : 32'd0;
        return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      end
      SEL_JUMP: return link;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic               is_rem;
    is_rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (op == OP_DIV || op == OP_REM) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return is_rem ? r[31:0] : q[31:0];
  endfunction

  function automatic int div_lat(input logic [31:0] b);
    return (b == 32'd0) ? 2 : 34;
  endfunction

  // Model timing: how many consecutive cycles the current DIV has sat in EX.
  always @(posedge clk) begin
    if (rst) div_age <= 0;
    else if (bus.alusel_i == SEL_DIV)
      div_age <= (div_age == div_lat(bus.reg2_i) - 1) ? 0 : div_age + 1;
    else div_age <= 0;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        is_div, done, exp_stall;
    logic [31:0] exp_w;
    if (rst) begin
      chk("rst_wd",    {27'd0, bus.wd_o}, 32'd0);
      chk("rst_wreg",  {31'd0, bus.wreg_o}, 32'd0);
      chk("rst_wdata", bus.wdata_o, 32'd0);
      chk("rst_aluop", {24'd0, bus.aluop_o}, {24'd0, OP_NOP});
      chk("rst_maddr", bus.mem_addr_o, 32'd0);
      chk("rst_reg2",  bus.reg2_o, 32'd0);
      chk("rst_stall", {31'd0, bus.stallreq_o}, 32'd0);
    end else begin
      is_div    = (bus.alusel_i == SEL_DIV);
      done      = is_div && (div_age == div_lat(bus.reg2_i) - 1);
      exp_stall = is_div && !done;
      exp_w     = is_div ? (done ? ref_div(bus.aluop_i, bus.reg1_i, bus.reg2_i) : 32'd0)
                         : ref_alu(bus.alusel_i, bus.aluop_i, bus.reg1_i, bus.reg2_i, bus.link_addr_i);
      chk("wd",    {27'd0, bus.wd_o}, {27'd0, bus.wd_i});
      chk("wreg",  {31'd0, bus.wreg_o}, {31'd0, bus.wreg_i});
      chk("aluop", {24'd0, bus.aluop_o}, {24'd0, bus.aluop_i});
      chk("maddr", bus.mem_addr_o, bus.reg1_i + bus.offset_i);
      chk("reg2",  bus.reg2_o, bus.reg2_i);
      chk("stall", {31'd0, bus.stallreq_o}, {31'd0, exp_stall});
      chk("wdata", bus.wdata_o, exp_w);
    end
  end

  task automatic set_inputs(input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    bus.alusel_i    = sel;
    bus.aluop_i     = op;
    bus.reg1_i      = a;
    bus.reg2_i      = b;
    bus.wd_i        = 5'($urandom);
    bus.wreg_i      = 1'($urandom);
    bus.link_addr_i = $urandom;
    bus.offset_i    = $urandom;
  endtask

  // Present one instruction and hold it for its full residency in EX.
  task automatic issue(input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output int stall_cycles, output logic [31:0] last_w);
    int n;
    set_inputs(sel, op, a, b);
    n = (sel == SEL_DIV) ? div_lat(b) : 1;
    stall_cycles = 0;
    last_w = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.stallreq_o) stall_cycles++;
      last_w = bus.wdata_o;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          sc;
    logic [31:0] w, a, b;
    logic [7:0]  op;

    set_inputs(SEL_DIV, OP_DIV, $urandom, $urandom | 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Model pins.
    chk("pin_model_add",  ref_alu(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0), 32'h8000_0000);
    chk("pin_model_sra",  ref_alu(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 32'd0), 32'hF800_0000);
    chk("pin_model_div",  ref_div(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_model_rem",  ref_div(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_model_ovf",  ref_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Directed pins on the DUT.
    issue(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, sc, w);
    chk("add_ovf", w, 32'h8000_0000);
    chk("add_stall", 32'(sc), 32'd0);
    issue(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, sc, w);
    chk("sra", w, 32'hF800_0000);
    issue(SEL_ARITH, OP_SLTU, 32'd1, 32'hFFFF_FFFF, sc, w);
    chk("sltu", w, 32'd1);
    issue(SEL_ARITH, OP_SLT, 32'd1, 32'hFFFF_FFFF, sc, w);
    chk("slt", w, 32'd0);
    issue(SEL_DIV, OP_DIV, 32'hFFFF_FFF9, 32'd2, sc, w);
    chk("div_m7_2", w, 32'hFFFF_FFFD);
    chk("div_stall_cycles", 32'(sc), 32'd33);
    issue(SEL_DIV, OP_REM, 32'hFFFF_FFF9, 32'd2, sc, w);
    chk("rem_m7_2", w, 32'hFFFF_FFFF);
    issue(SEL_DIV, OP_DIVU, 32'd100, 32'd0, sc, w);
    chk("divu_by0", w, 32'hFFFF_FFFF);
    chk("divu_by0_stall", 32'(sc), 32'd1);
    issue(SEL_DIV, OP_REMU, 32'd100, 32'd0, sc, w);
    chk("remu_by0", w, 32'd100);
    issue(SEL_DIV, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, w);
    chk("div_ovf", w, 32'h8000_0000);
    issue(SEL_DIV, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, sc, w);
    chk("rem_ovf", w, 32'd0);

    // Reset pulse during BUSY cycle 10, then a fresh DIVU.
    set_inputs(SEL_DIV, OP_DIVU, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    set_inputs(SEL_DIV, OP_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    chk("rst_mid_busy_stall", {31'd0, bus.stallreq_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(SEL_DIV, OP_DIVU, 32'd9, 32'd3, sc, w);
    chk("divu_after_rst", w, 32'd3);
    chk("divu_after_rst_stall", 32'(sc), 32'd33);

    // Randomized instruction stream, back-to-back DIVs included.
    for (int k = 0; k < 250; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: issue(SEL_NOP, OP_NOP, a, b, sc, w);
        1: begin
          case ($urandom_range(0, 2))
            0: op = OP_AND;
            1: op = OP_OR;
            default: op = OP_XOR;
          endcase
          issue(SEL_LOGIC, op, a, b, sc, w);
        end
        2: begin
          case ($urandom_range(0, 2))
            0: op = OP_SLL;
            1: op = OP_SRL;
            default: op = OP_SRA;
          endcase
          issue(SEL_SHIFT, op, a, b, sc, w);
        end
        3: begin
          case ($urandom_range(0, 5))
            0: op = OP_ADD;
            1: op = OP_ADDU;
            2: op = OP_SUB;
            3: op = OP_SUBU;
            4: op = OP_SLT;
            default: op = OP_SLTU;
          endcase
          issue(SEL_ARITH, op, a, b, sc, w);
        end
        4: issue(SEL_JUMP, OP_NOP, a, b, sc, w);
        5: issue(SEL_LOADSTORE, OP_LW, a, b, sc, w);
        default: begin
          case ($urandom_range(0, 3))
            0: op = OP_DIV;
            1: op = OP_DIVU;
            2: op = OP_REM;
            default: op = OP_REMU;
          endcase
          case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
          endcase
          issue(SEL_DIV, op, a, b, sc, w);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
